div16x8_seq: RTL and testbench

//  Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient + 8-bit remainder.
//  One quotient bit per clk; start/done handshake; FSM state driven to a 7-segment display.

---
 rtl/div16x8_seq.sv | 144 ++++++++++++++
 tb/tb_div16x8_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div16x8_seq.sv
// rtl/div16x8_seq.sv - sequential restoring divider, 16b / 8b, one quotient bit per clock
// FSM IDLE/LOAD/CALC/DONE/ERR with start edge detect and active-low 7-segment state display.
module div16x8_seq #(
  parameter int DW_N = 16,
  parameter int DW_D = 8
) (
  input  logic            clk,
  input  logic            reset_a,
  input  logic [DW_N-1:0] dataa,
  input  logic [DW_D-1:0] datab,
  input  logic            start,
  output logic [DW_N-1:0] quotient_out,
  output logic [DW_D-1:0] remainder_out,
  output logic            done_flag,
  output logic            busy,
  output logic            div_by_zero,
  output logic [2:0]      state_out,
  output logic            seg_a,
  output logic            seg_b,
  output logic            seg_c,
  output logic            seg_d,
  output logic            seg_e,
  output logic            seg_f,
  output logic            seg_g
);

  localparam int CNT_W = $clog2(DW_N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW_N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              start_d_q;
  logic [DW_N-1:0]   q_reg_q, q_reg_d;
  logic [DW_D-1:0]   d_reg_q, d_reg_d;
  logic [DW_D-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DW_N-1:0]   quot_out_q, quot_out_d;
  logic [DW_D-1:0]   rem_out_q, rem_out_d;

  logic              start_rise;
  logic [DW_D:0]     shifted;
  logic [DW_D:0]     trial;
  logic              qbit;
  logic [6:0]        seg;

  assign start_rise = start & ~start_d_q;

  // Partial remainder is always below the divisor, so the shifted value fits DW_D+1 bits
  // and bit DW_D of the trial difference is the borrow.
  assign shifted = {rem_q, q_reg_q[DW_N-1]};
  assign trial   = shifted - {1'b0, d_reg_q};
  assign qbit    = ~trial[DW_D];

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q    <= S_IDLE;
      start_d_q  <= 1'b0;
      q_reg_q    <= '0;
      d_reg_q    <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      start_d_q  <= start;
      q_reg_q    <= q_reg_d;
      d_reg_q    <= d_reg_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    q_reg_d    = q_reg_q;
    d_reg_d    = d_reg_q;
    rem_d      = rem_q;
    count_d    = count_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_rise) state_d = S_LOAD;
      end
      S_LOAD: begin
        q_reg_d = dataa;
        d_reg_d = datab;
        rem_d   = '0;
        count_d = '0;
        if (datab == '0) begin
          state_d    = S_ERR;
          quot_out_d = '1;
          rem_out_d  = '0;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d   = qbit ? trial[DW_D-1:0] : shifted[DW_D-1:0];
        q_reg_d = {q_reg_q[DW_N-2:0], qbit};
        count_d = count_q + 1'b1;
        // Results are captured from the next-state values so the final bit is included.
        if (count_q == LAST_CNT) begin
          state_d    = S_DONE;
          quot_out_d = q_reg_d;
          rem_out_d  = rem_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (state_q)
      S_IDLE: seg = 7'b0000001;
      S_LOAD: seg = 7'b1001111;
      S_CALC: seg = 7'b0010010;
      S_DONE: seg = 7'b0000110;
      S_ERR:  seg = 7'b1001100;
      default: seg = 7'b1111111;
    endcase
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;

  assign quotient_out  = quot_out_q;
  assign remainder_out = rem_out_q;
  assign state_out     = state_q;
  assign done_flag     = (state_q == S_DONE) || (state_q == S_ERR);
  assign busy          = (state_q == S_LOAD) || (state_q == S_CALC);
  assign div_by_zero   = (state_q == S_ERR);

endmodule

// File: tb/tb_div16x8_seq.sv
// tb/tb_div16x8_seq.sv - scoreboard bench for div16x8_seq
// Directed divisions with hand-computed results; a monitor pops expectations on each done rise.
module tb_div16x8_seq;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic [15:0] dataa = '0;
  logic [7:0]  datab = '0;
  logic        start = 1'b0;
  logic [15:0] quotient_out;
  logic [7:0]  remainder_out;
  logic        done_flag, busy, div_by_zero;
  logic [2:0]  state_out;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  int tests = 0;
  int fails = 0;
  logic [24:0] sb_q[$];
  logic        prev_done = 1'b0;

  div16x8_seq dut (
    .clk(clk), .reset_a(reset_a), .dataa(dataa), .datab(datab), .start(start),
    .quotient_out(quotient_out), .remainder_out(remainder_out), .done_flag(done_flag),
    .busy(busy), .div_by_zero(div_by_zero), .state_out(state_out),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d), .seg_e(seg_e),
    .seg_f(seg_f), .seg_g(seg_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input logic [2:0] code);
    case (code)
      3'd0: return 7'b0000001;
      3'd1: return 7'b1001111;
      3'd2: return 7'b0010010;
      3'd3: return 7'b0000110;
      3'd4: return 7'b1001100;
      default: return 7'b1111111;
    endcase
  endfunction

  // {busy, done, state, segs}
  function automatic logic [11:0] status_exp(input logic [2:0] code);
    return {code == 3'd1 || code == 3'd2, code == 3'd3 || code == 3'd4, code, seg_exp(code)};
  endfunction

  function automatic logic [11:0] status_act();
    return {busy, done_flag, state_out, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  endfunction

  always @(negedge clk) begin
    if (done_flag && !prev_done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: done with q=%0d r=%0d, nothing expected", quotient_out, remainder_out);
      end else begin
        check("result{dbz,q,r}", {7'd0, div_by_zero, quotient_out, remainder_out}, {7'd0, sb_q.pop_front()});
      end
    end
    prev_done <= done_flag;
  end

  // Runs one operation and leaves start high; glitch toggles start and the operands mid-CALC.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input bit glitch, input string tag);
    int cyc;
    int exp_lat;
    bit got;
    logic [2:0] es;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    sb_q.push_back({b == 8'd0, eq, er});
    exp_lat = (b == 8'd0) ? 2 : 18;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      cyc = i;
      if (glitch && i == 3) begin dataa = 16'h1234; datab = 8'h00; end
      if (glitch && i == 4) start = 1'b0;
      if (glitch && i == 6) start = 1'b1;
      if (glitch && i == 8) start = 1'b0;
      if (glitch && i == 10) start = 1'b1;
      if (i == 1) es = 3'd1;
      else if (b == 8'd0) es = 3'd4;
      else if (i < 18) es = 3'd2;
      else es = 3'd3;
      if (i <= exp_lat && (i <= 2 || i >= 17)) check({tag, "_status"}, {20'd0, status_act()}, {20'd0, status_exp(es)});
      if (done_flag) got = 1'b1;
    end
    check({tag, "_latency"}, cyc, exp_lat);
  endtask

  initial begin
    #1;
    check("reset_outputs", {quotient_out, remainder_out}, 24'd0);
    check("reset_status", {20'd0, status_act(), div_by_zero}, {20'd0, status_exp(3'd0), 1'b0});
    @(negedge clk);
    reset_a = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_hold", {29'd0, state_out}, 32'd0);

    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, "t1_1000_7");
    run_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, "t2_65535_1");
    run_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, "t2_65535_255");
    run_op(16'd5, 8'd200, 16'd0, 8'd5, 1'b0, "t3_5_200");
    run_op(16'd255, 8'd255, 16'd1, 8'd0, 1'b0, "t3_255_255");
    run_op(16'd1000, 8'd0, 16'hFFFF, 8'd0, 1'b0, "t4_div0");
    run_op(16'd12345, 8'd100, 16'd123, 8'd45, 1'b0, "t_12345_100");
    run_op(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, "t_40000_3");
    run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b1, "t5_glitch");

    // start still high: DONE must hold without retriggering
    repeat (6) @(negedge clk);
    check("t6_hold_state", {29'd0, state_out}, 32'd3);
    check("t6_hold_result", {8'd0, quotient_out, remainder_out}, {8'd0, 16'd142, 8'd6});

    // abort mid-CALC with asynchronous reset
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dataa = 16'd999;
    datab = 8'd9;
    start = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_pre_calc", {29'd0, state_out}, 32'd2);
    #2 reset_a = 1'b1;
    #1;
    check("abort_outputs", {quotient_out, remainder_out}, 24'd0);
    check("abort_status", {20'd0, status_act(), div_by_zero}, {20'd0, status_exp(3'd0), 1'b0});
    @(negedge clk);
    reset_a = 1'b0;
    start = 1'b0;

    run_op(16'd999, 8'd9, 16'd111, 8'd0, 1'b0, "post_reset");
    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
